// File: rtl/run_sequencer.sv
// Run sequencer for the 9-bit core: host handshake, core reset hold, run/timeout tracking.
// Optional breakpoint/halt support is built when RUN_SEQ_BREAKPOINT_EN is defined.
module run_sequencer #(
   parameter int unsigned D       = 12,
   parameter int unsigned CW      = 16,
   parameter int unsigned DONE_PC = 128,
   parameter int unsigned RST_CYC = 4,
   parameter int unsigned TIMEOUT = 32'h0000_FFFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req_i,
   input  logic [D-1:0]  prog_ctr_i,
`ifdef RUN_SEQ_BREAKPOINT_EN
   input  logic          bp_en_i,
   input  logic [D-1:0]  bp_addr_i,
   input  logic          resume_i,
   output logic          halted_o,
`endif
   output logic          core_reset_o,
   output logic          core_en_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          timeout_o,
   output logic [CW-1:0] cycle_cnt_o
);

   localparam int unsigned   HW        = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_CYC - 1);
   localparam logic [D-1:0]  DONE_PC_V = D'(DONE_PC);
   localparam logic [CW-1:0] TIMEOUT_V = CW'(TIMEOUT);
   localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RST  = 3'd1,
      S_RUN  = 3'd2,
      S_DONE = 3'd3
`ifdef RUN_SEQ_BREAKPOINT_EN
      , S_HALT = 3'd4
`endif
   } state_e;

   state_e        state_q, state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          timeout_q, timeout_d;
   logic          core_reset_q, core_reset_d;
   logic          core_en_q, core_en_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
`ifdef RUN_SEQ_BREAKPOINT_EN
   logic          halted_q, halted_d;
   logic          bp_mask_q, bp_mask_d;
`endif

   // NOTE: state uses non-blocking assignments only; every _q has its _d computed combinationally.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         hold_q       <= '0;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         core_reset_q <= 1'b1;
         core_en_q    <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
`ifdef RUN_SEQ_BREAKPOINT_EN
         halted_q     <= 1'b0;
         bp_mask_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         cnt_q        <= cnt_d;
         timeout_q    <= timeout_d;
         core_reset_q <= core_reset_d;
         core_en_q    <= core_en_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
`ifdef RUN_SEQ_BREAKPOINT_EN
         halted_q     <= halted_d;
         bp_mask_q    <= bp_mask_d;
`endif
      end
   end

   // NOTE: every variable gets a default before the case so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      hold_d    = hold_q;
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`ifdef RUN_SEQ_BREAKPOINT_EN
      bp_mask_d = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_i) begin
               state_d   = S_RST;
               hold_d    = '0;
               cnt_d     = '0;
               timeout_d = 1'b0;
            end
         end
         S_RST: begin
            if (hold_q == HOLD_LAST) state_d = S_RUN;
            else                     hold_d  = hold_q + 1'b1;
         end
         S_RUN: begin
            // End-of-program match wins over timeout; its cycle is not counted.
            if (prog_ctr_i == DONE_PC_V) begin
               state_d = S_DONE;
            end else if (cnt_q == TIMEOUT_V) begin
               state_d   = S_DONE;
               timeout_d = 1'b1;
            end else begin
               if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
`ifdef RUN_SEQ_BREAKPOINT_EN
               if (bp_en_i && !bp_mask_q && (prog_ctr_i == bp_addr_i)) state_d = S_HALT;
`endif
            end
         end
         S_DONE: begin
            if (!req_i) state_d = S_IDLE;
         end
`ifdef RUN_SEQ_BREAKPOINT_EN
         S_HALT: begin
            // The mask suppresses the breakpoint for the first cycle back in RUN.
            if (resume_i) begin
               state_d   = S_RUN;
               bp_mask_d = 1'b1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they are registered alongside it.
   always_comb begin
      core_reset_d = 1'b1;
      core_en_d    = 1'b0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
`ifdef RUN_SEQ_BREAKPOINT_EN
      halted_d     = 1'b0;
`endif
      case (state_d)
         S_RST: begin
            busy_d = 1'b1;
         end
         S_RUN: begin
            core_reset_d = 1'b0;
            core_en_d    = 1'b1;
            busy_d       = 1'b1;
         end
         S_DONE: begin
            core_reset_d = 1'b0;
            done_d       = 1'b1;
         end
`ifdef RUN_SEQ_BREAKPOINT_EN
         S_HALT: begin
            core_reset_d = 1'b0;
            busy_d       = 1'b1;
            halted_d     = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   assign core_reset_o = core_reset_q;
   assign core_en_o    = core_en_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign timeout_o    = timeout_q;
   assign cycle_cnt_o  = cnt_q;
`ifdef RUN_SEQ_BREAKPOINT_EN
   assign halted_o     = halted_q;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed self-checking bench for run_sequencer; a tiny program-counter model stands in for the core.
// Breakpoint scenario is compiled only when RUN_SEQ_BREAKPOINT_EN is defined.
module tb_run_sequencer;

   localparam int D       = 12;
   localparam int CW      = 16;
   localparam int RST_CYC = 4;
   localparam int TO      = 60;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic [D-1:0]  prog_ctr;
   logic          core_reset, core_en, busy, done, timeout;
   logic [CW-1:0] cycle_cnt;
`ifdef RUN_SEQ_BREAKPOINT_EN
   logic          bp_en = 1'b0;
   logic [D-1:0]  bp_addr = '0;
   logic          resume = 1'b0;
   logic          halted;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Core model: PC counts enabled cycles from 0 and jumps to 128 after match_at of them.
   int           en_count;
   int           match_at = 1000;
   logic         pc_ovr_en = 1'b0;
   logic [D-1:0] pc_ovr = '0;

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)          en_count <= 0;
      else if (core_reset) en_count <= 0;
      else if (core_en)    en_count <= en_count + 1;
   end

   assign prog_ctr = pc_ovr_en ? pc_ovr :
                     (en_count == match_at) ? D'(128) : D'(en_count);

   run_sequencer #(
      .D(D), .CW(CW), .DONE_PC(128), .RST_CYC(RST_CYC), .TIMEOUT(TO)
   ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_i        (req),
      .prog_ctr_i   (prog_ctr),
`ifdef RUN_SEQ_BREAKPOINT_EN
      .bp_en_i      (bp_en),
      .bp_addr_i    (bp_addr),
      .resume_i     (resume),
      .halted_o     (halted),
`endif
      .core_reset_o (core_reset),
      .core_en_o    (core_en),
      .busy_o       (busy),
      .done_o       (done),
      .timeout_o    (timeout),
      .cycle_cnt_o  (cycle_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // req rises in cycle 0; core_en must appear exactly RST_CYC+1 edges later.
   task automatic start_run(input string tag);
      req = 1'b1;
      tick();
      check({tag, "_busy_rst"}, 32'(busy), 32'd1);
      check({tag, "_cnt_clr"}, 32'(cycle_cnt), 32'd0);
      check({tag, "_to_clr"}, 32'(timeout), 32'd0);
      tick(RST_CYC - 1);
      check({tag, "_en_low"}, 32'(core_en), 32'd0);
      tick();
      check({tag, "_en_rise"}, 32'(core_en), 32'd1);
      check({tag, "_crst_fall"}, 32'(core_reset), 32'd0);
   endtask

   // Waits for the end-of-program address, then expects done exactly one edge later.
   task automatic run_to_match(input string tag);
      int k = 0;
      while (prog_ctr != D'(128) && k < 500) begin
         tick();
         k++;
      end
      check({tag, "_match_seen"}, 32'(prog_ctr), 32'd128);
      check({tag, "_done_pre"}, 32'(done), 32'd0);
      tick();
      check({tag, "_done"}, 32'(done), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_en_done"}, 32'(core_en), 32'd0);
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (!done && k < 500) begin
         tick();
         k++;
      end
      check({tag, "_done_seen"}, 32'(done), 32'd1);
   endtask

   task automatic end_run(input string tag);
      req = 1'b0;
      tick();
      check({tag, "_done_fall"}, 32'(done), 32'd0);
      check({tag, "_crst_idle"}, 32'(core_reset), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // 1: reset values, then idle with req low
      #12;
      check("rst_crst", 32'(core_reset), 32'd1);
      check("rst_en", 32'(core_en), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         check("idle_crst", 32'(core_reset), 32'd1);
         check("idle_en", 32'(core_en), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_cnt", 32'(cycle_cnt), 32'd0);
      end

      // 2: normal run, 50 counted cycles
      match_at = 50;
      start_run("norm");
      run_to_match("norm");
      check("norm_cnt", 32'(cycle_cnt), 32'd50);
      check("norm_to", 32'(timeout), 32'd0);
      check("norm_crst_done", 32'(core_reset), 32'd0);
      end_run("norm");
      check("norm_cnt_kept", 32'(cycle_cnt), 32'd50);

      // 3: timeout, recovery, and timeout coinciding with the match
      match_at = 1000;
      start_run("tout");
      wait_done("tout");
      check("tout_flag", 32'(timeout), 32'd1);
      check("tout_cnt", 32'(cycle_cnt), 32'd60);
      end_run("tout");
      check("tout_kept", 32'(timeout), 32'd1);
      match_at = 10;
      start_run("rec");
      run_to_match("rec");
      check("rec_cnt", 32'(cycle_cnt), 32'd10);
      check("rec_to", 32'(timeout), 32'd0);
      end_run("rec");
      match_at = 60;
      start_run("tie");
      run_to_match("tie");
      check("tie_cnt", 32'(cycle_cnt), 32'd60);
      check("tie_to", 32'(timeout), 32'd0);
      end_run("tie");

      // 4: req dropped in RUN, then req held high after done
      match_at = 30;
      start_run("drop");
      tick(2);
      req = 1'b0;
      run_to_match("drop");
      tick();
      check("drop_pulse", 32'(done), 32'd0);
      check("drop_crst", 32'(core_reset), 32'd1);
      tick(2);
      check("drop_idle", 32'(busy), 32'd0);
      match_at = 20;
      start_run("hold");
      run_to_match("hold");
      tick(5);
      check("hold_done", 32'(done), 32'd1);
      check("hold_busy", 32'(busy), 32'd0);
      check("hold_en", 32'(core_en), 32'd0);
      end_run("hold");
      tick(3);
      check("hold_norestart", 32'(busy), 32'd0);

      // 5: async reset in the middle of a run
      match_at = 1000;
      start_run("arst");
      begin
         int k = 0;
         while (cycle_cnt != CW'(7) && k < 100) begin
            tick();
            k++;
         end
      end
      check("arst_cnt7", 32'(cycle_cnt), 32'd7);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_crst", 32'(core_reset), 32'd1);
      check("arst_en", 32'(core_en), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cnt", 32'(cycle_cnt), 32'd0);
      req = 1'b0;
      tick(2);
      @(negedge clk);
      rst_n = 1'b1;
      tick(2);
      match_at = 15;
      start_run("post");
      run_to_match("post");
      check("post_cnt", 32'(cycle_cnt), 32'd15);
      end_run("post");

`ifdef RUN_SEQ_BREAKPOINT_EN
      // 6: breakpoint at 40, hold, resume past it, finish at 128
      match_at = 50;
      bp_addr  = D'(40);
      bp_en    = 1'b1;
      start_run("bp");
      begin
         int k = 0;
         while (!halted && k < 200) begin
            tick();
            k++;
         end
      end
      pc_ovr    = D'(40);
      pc_ovr_en = 1'b1;
      check("bp_halted", 32'(halted), 32'd1);
      check("bp_en_low", 32'(core_en), 32'd0);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_cnt", 32'(cycle_cnt), 32'd41);
      tick(10);
      check("bp_cnt_hold", 32'(cycle_cnt), 32'd41);
      check("bp_still", 32'(halted), 32'd1);
      resume = 1'b1;
      tick();
      resume = 1'b0;
      check("bp_resume_en", 32'(core_en), 32'd1);
      check("bp_resume_h", 32'(halted), 32'd0);
      tick();
      check("bp_no_rehalt", 32'(halted), 32'd0);
      pc_ovr_en = 1'b0;
      run_to_match("bp");
      check("bp_final_cnt", 32'(cycle_cnt), 32'd50);
      end_run("bp");
      bp_en = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
